// File: rtl/controlador_seq_if.sv
// rtl/controlador_seq_if.sv - opcode/flag inputs, T-state and control word of the SAP sequencer
interface controlador_seq_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] a;
  logic                z;
  logic                n;
  logic [5:0]          t;
  logic                cp, ep, eu, ea, su;
  logic                n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_lp, n_hlt;

  modport master (
    input  a, z, n,
    output t, cp, ep, eu, ea, su,
    output n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_lp, n_hlt
  );

  modport slave (
    output a, z, n,
    input  t, cp, ep, eu, ea, su,
    input  n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0, n_lp, n_hlt
  );
endinterface

// File: rtl/controlador_seq.sv
// rtl/controlador_seq.sv - SAP sequencing controller: internal ring counter, decode, wait stretching
// Optional jumps (JMP/JZ/JN) enabled by defining CTRL_JUMP_EN.
module controlador_seq #(
  parameter int OPCODE_W = 4,
  parameter int WAIT_CYC = 0
) (
  input logic               clk,
  input logic               n_clr,
  controlador_seq_if.master bus
);
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  localparam logic [2:0] WMAX = 3'(WAIT_CYC);

  logic [5:0]          t_q;
  logic [2:0]          wcnt;
  logic                halt_q;
  logic [OPCODE_W-1:0] op;

  logic is_lda, is_add, is_sub, is_out, is_hlt, is_alu, is_jcls, jmp_take;
  logic s1, s2, s3, s4, s5, s6;
  logic mem_rd, hold, last, halt_now, act;

  assign op     = bus.a;
  assign is_lda = (op == OPCODE_W'(0));
  assign is_add = (op == OPCODE_W'(1));
  assign is_sub = (op == OPCODE_W'(2));
  assign is_out = (op == OPCODE_W'(14));
  assign is_hlt = (op == {OPCODE_W{1'b1}});
  assign is_alu = is_lda | is_add | is_sub;

`ifdef CTRL_JUMP_EN
  logic is_jmp, is_jz, is_jn;
  assign is_jmp   = (op == OPCODE_W'(3));
  assign is_jz    = (op == OPCODE_W'(4));
  assign is_jn    = (op == OPCODE_W'(5));
  assign is_jcls  = is_jmp | is_jz | is_jn;
  assign jmp_take = (t_q == T4) & (is_jmp | (is_jz & bus.z) | (is_jn & bus.n));
`else
  logic unused_flags;
  assign unused_flags = bus.z ^ bus.n;
  assign is_jcls      = 1'b0;
  assign jmp_take     = 1'b0;
`endif

  // Decoded controls are gated off once halted so a changing opcode cannot wake the bus.
  assign act = ~halt_q;
  assign s1  = act & (t_q == T1);
  assign s2  = act & (t_q == T2);
  assign s3  = act & (t_q == T3);
  assign s4  = act & (t_q == T4);
  assign s5  = act & (t_q == T5);
  assign s6  = act & (t_q == T6);

  assign mem_rd   = (t_q == T3) | ((t_q == T5) & is_alu);
  assign hold     = mem_rd & (wcnt != WMAX);
  assign last     = ((t_q == T3) & ~(is_alu | is_out | is_jcls | is_hlt))
                  | ((t_q == T4) & (is_out | is_jcls))
                  | (t_q == T6);
  assign halt_now = halt_q | ((t_q == T4) & is_hlt);

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      t_q    <= T1;
      wcnt   <= 3'd0;
      halt_q <= 1'b0;
    end else if (halt_now) begin
      halt_q <= 1'b1;
      wcnt   <= 3'd0;
    end else if (hold) begin
      wcnt <= wcnt + 3'd1;
    end else begin
      wcnt <= 3'd0;
      t_q  <= last ? T1 : {t_q[4:0], 1'b0};
    end
  end

  assign bus.t     = t_q;
  assign bus.ep    = s1;
  assign bus.cp    = s2;
  assign bus.eu    = s6 & (is_add | is_sub);
  assign bus.su    = s6 & is_sub;
  assign bus.ea    = s4 & is_out;
  assign bus.n_lm  = ~(s1 | (s4 & is_alu));
  assign bus.n_ce  = ~(s3 | (s5 & is_alu));
  assign bus.n_l1  = ~s3;
  assign bus.n_e1  = ~((s4 & is_alu) | (act & jmp_take));
  assign bus.n_la  = ~((s5 & is_lda) | (s6 & (is_add | is_sub)));
  assign bus.n_lb  = ~(s5 & (is_add | is_sub));
  assign bus.n_l0  = ~(s4 & is_out);
  assign bus.n_lp  = ~(act & jmp_take);
  assign bus.n_hlt = ~halt_now;
endmodule
